// File: rtl/compute_rwd_seq.sv
// Time-multiplexed weighted sum-of-squares reward: rwd = -(sum_k w_k * x_k^2) in float32.
// One shared squaring multiplier and one shared MAC; both cores are unreset delay-line pipelines.
module compute_rwd_seq #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned DATA_WL = 32,
  parameter int unsigned MUL_LAT = 8,
  parameter int unsigned MAC_LAT = 16,
  parameter int unsigned NEGATE  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [N_CH*DATA_WL-1:0]   i_x,
  input  logic [N_CH*DATA_WL-1:0]   i_w,
  output logic                      o_rwd_valid,
  input  logic                      i_rwd_ready,
  output logic [DATA_WL-1:0]        o_rwd,
  output logic                      o_nan,
  output logic                      o_busy
);

  localparam int unsigned IW        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned FLUSH_CYC = ((MUL_LAT > MAC_LAT) ? MUL_LAT : MAC_LAT) + 1;
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);
  localparam logic [IW-1:0] LAST    = IW'(N_CH - 1);
  localparam logic [DATA_WL-1:0] SIGN_FLIP =
    (NEGATE != 0) ? {1'b1, {(DATA_WL-1){1'b0}}} : '0;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_SQ, S_ACC_ISSUE, S_ACC_WAIT, S_DONE
  } state_t;

  // Round-to-nearest-even and pack; subnormal results flush to signed zero.
  function automatic logic [31:0] f_round_pack(input logic sgn, input int e,
                                               input logic [22:0] m, input logic g,
                                               input logic st);
    logic [23:0] mr;
    int          ee;
    ee = e;
    mr = {1'b0, m};
    if (g && (st || m[0])) mr = mr + 24'd1;
    if (mr[23]) ee = ee + 1;
    if (ee >= 255) return {sgn, 8'hFF, 23'h0};
    if (ee <= 0)   return {sgn, 31'h0};
    return {sgn, ee[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_z, b_z;
    logic [47:0] p;
    int          e;
    sgn   = a[31] ^ b[31];
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    a_z   = (a[30:23] == 8'h00);
    b_z   = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {sgn, 8'hFF, 23'h0};
    if (a_z || b_z)     return {sgn, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(32'(a[30:23])) + int'(32'(b[30:23])) - 127;
    if (p[47]) return f_round_pack(sgn, e + 1, p[46:24], p[23], |p[22:0]);
    return f_round_pack(sgn, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [49:0] mx, my, ys, sum;
    logic        a_nan, b_nan, a_inf, b_inf, a_z, b_z, found;
    int unsigned d;
    int          e, sh;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    a_z   = (a[30:23] == 8'h00);
    b_z   = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_z && b_z) return {a[31] & b[31], 31'h0};
    if (a_z) return b;
    if (b_z) return a;
    if (b[30:0] > a[30:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    d  = 32'(x[30:23]) - 32'(y[30:23]);
    mx = {2'b01, x[22:0], 25'h0};
    my = {2'b01, y[22:0], 25'h0};
    if (d > 49) begin
      ys = 50'd1;
    end else begin
      ys = my >> d;
      if ((ys << d) != my) ys[0] = 1'b1;
    end
    sum = (x[31] == y[31]) ? (mx + ys) : (mx - ys);
    e   = int'(32'(x[30:23]));
    if (sum == 50'd0) return 32'h0;
    if (sum[49]) begin
      sum = {1'b0, sum[49:2], sum[1] | sum[0]};
      e   = e + 1;
    end else begin
      found = 1'b0;
      sh    = 0;
      for (int i = 48; i >= 0; i--) begin
        if (!found && sum[i]) begin
          found = 1'b1;
          sh    = 48 - i;
        end
      end
      sum = sum << sh;
      e   = e - sh;
    end
    return f_round_pack(x[31], e, sum[47:25], sum[24], |sum[23:0]);
  endfunction

  state_t               r_state, w_state_nxt;
  logic [FW-1:0]        r_flush_cnt;
  logic [IW-1:0]        r_iss_idx, r_wr_idx, r_k;
  logic                 r_iss_done;
  logic [DATA_WL-1:0]   r_acc;
  logic [DATA_WL-1:0]   r_x  [N_CH];
  logic [DATA_WL-1:0]   r_w  [N_CH];
  logic [DATA_WL-1:0]   r_sq [N_CH];
  logic                 r_ready, r_rwd_valid, r_nan, r_busy;
  logic [DATA_WL-1:0]   r_rwd;

  logic                 w_accept;
  logic [DATA_WL-1:0]   w_mul_a, w_mul_b, w_mul_res;
  logic                 w_mul_vld_in, w_mul_vld_out;
  logic [DATA_WL-1:0]   w_mac_a, w_mac_b, w_mac_c, w_mac_res;
  logic                 w_mac_vld_in, w_mac_vld_out;

  logic [DATA_WL-1:0]   r_mul_pipe  [MUL_LAT];
  logic                 r_mul_vpipe [MUL_LAT];
  logic [DATA_WL-1:0]   r_mac_pipe  [MAC_LAT];
  logic                 r_mac_vpipe [MAC_LAT];

  // Core models: no reset, so stale tvalids can surface after reset until flushed.
  always_ff @(posedge i_clk) begin
    r_mul_pipe[0]  <= f_mul(w_mul_a, w_mul_b);
    r_mul_vpipe[0] <= w_mul_vld_in;
    for (int i = 1; i < MUL_LAT; i++) begin
      r_mul_pipe[i]  <= r_mul_pipe[i-1];
      r_mul_vpipe[i] <= r_mul_vpipe[i-1];
    end
    r_mac_pipe[0]  <= f_add(f_mul(w_mac_a, w_mac_b), w_mac_c);
    r_mac_vpipe[0] <= w_mac_vld_in;
    for (int i = 1; i < MAC_LAT; i++) begin
      r_mac_pipe[i]  <= r_mac_pipe[i-1];
      r_mac_vpipe[i] <= r_mac_vpipe[i-1];
    end
  end

  assign w_mul_res     = r_mul_pipe[MUL_LAT-1];
  assign w_mul_vld_out = r_mul_vpipe[MUL_LAT-1];
  assign w_mac_res     = r_mac_pipe[MAC_LAT-1];
  assign w_mac_vld_out = r_mac_vpipe[MAC_LAT-1];
  assign w_accept      = r_ready && i_valid;

  // Next-state and core drive.
  always_comb begin
    w_state_nxt  = r_state;
    w_mul_a      = r_x[r_iss_idx];
    w_mul_b      = r_x[r_iss_idx];
    w_mul_vld_in = 1'b0;
    w_mac_a      = r_w[r_k];
    w_mac_b      = r_sq[r_k];
    w_mac_c      = (r_k == '0) ? '0 : r_acc;
    w_mac_vld_in = 1'b0;
    case (r_state)
      S_FLUSH:     if (r_flush_cnt == FW'(FLUSH_CYC - 1)) w_state_nxt = S_IDLE;
      S_IDLE:      if (w_accept) w_state_nxt = S_SQ;
      S_SQ: begin
        w_mul_vld_in = !r_iss_done;
        if (w_mul_vld_out && (r_wr_idx == LAST)) w_state_nxt = S_ACC_ISSUE;
      end
      S_ACC_ISSUE: begin
        w_mac_vld_in = 1'b1;
        w_state_nxt  = S_ACC_WAIT;
      end
      S_ACC_WAIT:  if (w_mac_vld_out) w_state_nxt = (r_k == LAST) ? S_DONE : S_ACC_ISSUE;
      S_DONE:      if (i_rwd_ready) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_FLUSH;
    endcase
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= '0;
      r_iss_idx   <= '0;
      r_iss_done  <= 1'b0;
      r_wr_idx    <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_ready     <= 1'b0;
      r_rwd_valid <= 1'b0;
      r_rwd       <= '0;
      r_nan       <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= (r_state == S_FLUSH) ? (r_flush_cnt + FW'(1)) : '0;
      if (w_accept) begin
        r_iss_idx  <= '0;
        r_iss_done <= 1'b0;
        r_wr_idx   <= '0;
        r_k        <= '0;
      end
      if (r_state == S_SQ) begin
        if (!r_iss_done) begin
          if (r_iss_idx == LAST) r_iss_done <= 1'b1;
          else                   r_iss_idx  <= r_iss_idx + IW'(1);
        end
        if (w_mul_vld_out && (r_wr_idx != LAST)) r_wr_idx <= r_wr_idx + IW'(1);
      end
      if ((r_state == S_ACC_WAIT) && w_mac_vld_out) begin
        r_acc <= w_mac_res;
        if (r_k != LAST) r_k <= r_k + IW'(1);
      end
      if ((r_state == S_ACC_WAIT) && (w_state_nxt == S_DONE)) begin
        r_rwd <= w_mac_res ^ SIGN_FLIP;
        r_nan <= (w_mac_res[30:23] == 8'hFF);
      end
      r_ready     <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rwd_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand and square storage; sampled only at handshake / multiplier writeback.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int k = 0; k < N_CH; k++) begin
        r_x[k] <= i_x[k*DATA_WL +: DATA_WL];
        r_w[k] <= i_w[k*DATA_WL +: DATA_WL];
      end
    end
    if ((r_state == S_SQ) && w_mul_vld_out) r_sq[r_wr_idx] <= w_mul_res;
  end

  assign o_ready     = r_ready;
  assign o_rwd_valid = r_rwd_valid;
  assign o_rwd       = r_rwd;
  assign o_nan       = r_nan;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_compute_rwd_seq.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop and compare.
module tb_compute_rwd_seq;

  typedef struct {
    logic [31:0] rwd;
    logic        nan;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_rwd_ready;
  logic [95:0] i_x, i_w;
  logic        rdy0, vld0, nan0, busy0, rdy1, vld1, nan1, busy1;
  logic [31:0] rwd0, rwd1;
  logic        i_valid2, i_rwd_ready2;
  logic [31:0] i_x2, i_w2;
  logic        rdy2, vld2, nan2, busy2;
  logic [31:0] rwd2;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$], q1[$], q2[$];
  bit   seen0 = 0, seen1 = 0, seen2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  compute_rwd_seq dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy0),
    .i_x(i_x), .i_w(i_w), .o_rwd_valid(vld0), .i_rwd_ready(i_rwd_ready),
    .o_rwd(rwd0), .o_nan(nan0), .o_busy(busy0));

  compute_rwd_seq #(.NEGATE(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy1),
    .i_x(i_x), .i_w(i_w), .o_rwd_valid(vld1), .i_rwd_ready(i_rwd_ready),
    .o_rwd(rwd1), .o_nan(nan1), .o_busy(busy1));

  compute_rwd_seq #(.N_CH(1), .MUL_LAT(2), .MAC_LAT(4)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid2), .o_ready(rdy2),
    .i_x(i_x2), .i_w(i_w2), .o_rwd_valid(vld2), .i_rwd_ready(i_rwd_ready2),
    .o_rwd(rwd2), .o_nan(nan2), .o_busy(busy2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input string tag, inout exp_t q[$], input logic [31:0] rwd,
                     input logic nan);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_unexpected_result"}, rwd, 32'hxxxx_xxxx);
    end else begin
      e = q.pop_front();
      chk({tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
      chk({tag, "_rwd"}, rwd, e.rwd);
      chk({tag, "_nan"}, 32'(nan), 32'(e.nan));
    end
  endtask

  // Monitors: compare on the first cycle each result is presented.
  always @(negedge clk) begin
    if (vld0 && !seen0) mon("d0", q0, rwd0, nan0);
    seen0 = vld0;
    if (vld1 && !seen1) mon("d1", q1, rwd1, nan1);
    seen1 = vld1;
    if (vld2 && !seen2) mon("d2", q2, rwd2, nan2);
    seen2 = vld2;
  end

  // Drives one vector into dut0/dut1; cost is the positive weighted sum of squares.
  task automatic send(input logic [95:0] x, input logic [95:0] w, input logic [31:0] cost,
                      input bit keep_valid, output int t0);
    int n;
    i_valid = 1'b1;
    i_x     = x;
    i_w     = w;
    n       = 0;
    while (!rdy0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      chk("accept_timeout", 32'(rdy0), 32'd1);
      t0 = -1000;
    end else begin
      t0 = cyc;
      q0.push_back('{cost ^ 32'h8000_0000, &cost[30:23], t0, 63});
      q1.push_back('{cost, &cost[30:23], t0, 63});
    end
    @(negedge clk);
    if (!keep_valid) i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || q2.size() > 0 || vld0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  localparam logic [95:0] X1 = {32'h4080_0000, 32'h4000_0000, 32'h3F80_0000};
  localparam logic [95:0] W1 = {32'h3E80_0000, 32'h3F00_0000, 32'h3F80_0000};
  localparam logic [95:0] X2 = {32'h4000_0000, 32'h3F80_0000, 32'h4040_0000};
  localparam logic [95:0] W2 = {32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
  localparam logic [95:0] WP = {32'h3A83_126F, 32'h3DCC_CCCD, 32'h3F80_0000};
  localparam logic [95:0] XI = {32'h0, 32'h0, 32'h7F80_0000};

  initial begin
    int t0a, t0b, n;
    rst_n = 1'b0; i_valid = 1'b0; i_rwd_ready = 1'b1; i_x = '0; i_w = '0;
    i_valid2 = 1'b0; i_rwd_ready2 = 1'b1; i_x2 = '0; i_w2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_rwd", rwd0, 32'h0);
    chk("rst_nan", 32'(nan0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    rst_n = 1'b1;

    // Basic vector: -(1*1 + 0.5*4 + 0.25*16) = -7.0
    send(X1, W1, 32'h40E0_0000, 1'b0, t0a);
    drain();
    // Zero state: signed zero result
    send(96'h0, WP, 32'h0000_0000, 1'b0, t0a);
    drain();
    // +Inf channel propagates and is flagged
    send(XI, W2, 32'h7F80_0000, 1'b0, t0a);
    drain();

    // Backpressure: result held, no accept while DONE
    i_rwd_ready = 1'b0;
    send(X2, W2, 32'h4160_0000, 1'b0, t0a);
    n = 0;
    while (!vld0 && n < 200) begin
      chk("inflight_ready", 32'(rdy0), 32'd0);
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 32'(vld0), 32'd1);
      chk("bp_rwd", rwd0, 32'hC160_0000);
      chk("bp_ready", 32'(rdy0), 32'd0);
      @(negedge clk);
    end
    i_rwd_ready = 1'b1;
    @(negedge clk);
    chk("post_accept_valid", 32'(vld0), 32'd0);
    chk("post_accept_ready", 32'(rdy0), 32'd1);
    drain();

    // Back-to-back with i_valid held and inputs changed mid-transaction
    send(X1, W1, 32'h40E0_0000, 1'b1, t0a);
    send(X2, W2, 32'h4160_0000, 1'b0, t0b);
    chk("b2b_second_accept", 32'(t0b - t0a), 32'd64);
    drain();

    // Reset mid-operation: in-flight result dropped, flush window, then clean run
    send(X2, W2, 32'h4160_0000, 1'b0, t0a);
    while (cyc < t0a + 30) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_valid", 32'(vld0), 32'd0);
    for (int i = 0; i < 17; i++) begin
      chk("flush_ready", 32'(rdy0), 32'd0);
      chk("flush_busy", 32'(busy0), 32'd1);
      @(negedge clk);
    end
    chk("flush_done_ready", 32'(rdy0), 32'd1);
    send(X1, W1, 32'h40E0_0000, 1'b0, t0a);
    drain();

    // Single channel, short latencies: -(1*3^2) = -9.0 at t0+9
    i_valid2 = 1'b1; i_x2 = 32'h4040_0000; i_w2 = 32'h3F80_0000;
    n = 0;
    while (!rdy2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d2_accept", 32'(rdy2), 32'd1);
    q2.push_back('{32'hC110_0000, 1'b0, cyc, 9});
    @(negedge clk);
    i_valid2 = 1'b0;
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
